// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default framing bytes and a small saturating-increment helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_ABORT = 2'd3
  } tx_state_t;

  localparam logic [7:0] UART_HDR_BASE   = 8'hA0;
  localparam logic [7:0] UART_ABORT_BYTE = 8'hEE;
  localparam int         UART_TMO_W      = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// Two-way packet-level round-robin pick: on contention the source that was
// not served last wins, otherwise whichever source is requesting.
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  always_comb begin
    grant = 1'b0;
    if (valid0 && valid1) begin
      grant = !last_grant;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

  assign any = valid0 | valid1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Merges two byte-stream requesters onto one UART TX sink, framing each packet
// with a source header and replacing stalled packets with an abort marker.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] HDR_BASE       = UART_HDR_BASE,
  parameter logic [7:0] ABORT_BYTE     = UART_ABORT_BYTE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_valid,
  input  logic       i_req0_last,
  output logic       o_req0_ready,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_valid,
  input  logic       i_req1_last,
  output logic       o_req1_ready,
  output logic [7:0] o_wdata,
  output logic       o_wvalid,
  input  logic       i_wready,
  output logic       o_busy,
  output logic       o_grant,
  output logic [7:0] o_abort_cnt
);

  localparam logic [UART_TMO_W-1:0] TMO_LAST = UART_TMO_W'(TIMEOUT_CYCLES - 1);

  tx_state_t             state_q, state_d;
  logic                  grant_q, last_grant_q;
  logic                  pick_grant, pick_any;
  logic [7:0]            wdata_q;
  logic                  wvalid_q;
  logic                  last_seen_q;
  logic [UART_TMO_W-1:0] tmo_q;
  logic [7:0]            abort_cnt_q;

  logic                  g_valid, g_last;
  logic [7:0]            g_data;
  logic                  accept_ok;
  logic                  in_xfer, out_xfer;
  logic                  tmo_tick, tmo_hit;

  rr_pick2 u_pick (
    .valid0     (i_req0_valid),
    .valid1     (i_req1_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  assign g_valid = grant_q ? i_req1_valid : i_req0_valid;
  assign g_last  = grant_q ? i_req1_last  : i_req0_last;
  assign g_data  = grant_q ? i_req1_data  : i_req0_data;

  assign in_xfer  = g_valid && accept_ok;
  assign out_xfer = wvalid_q && i_wready;

  // The stall timer only runs while nothing is buffered and the source is silent,
  // so sink back-pressure never counts toward an abort.
  assign tmo_tick = (state_q == ST_DATA) && !wvalid_q && !g_valid;
  assign tmo_hit  = tmo_tick && (tmo_q == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_HDR;
      ST_HDR:   if (out_xfer) state_d = ST_DATA;
      ST_DATA: begin
        if (out_xfer && last_seen_q) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: if (out_xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // While the header drains, the first payload byte may already be loaded behind
  // it, which keeps header and payload back to back on the wire.
  always_comb begin
    o_busy    = 1'b0;
    accept_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_busy    = 1'b0;
        accept_ok = 1'b0;
      end
      ST_HDR, ST_DATA: begin
        o_busy    = 1'b1;
        accept_ok = !last_seen_q && (!wvalid_q || i_wready);
      end
      ST_ABORT: o_busy = 1'b1;
      default:  o_busy = 1'b0;
    endcase
    o_req0_ready = accept_ok && !grant_q;
    o_req1_ready = accept_ok && grant_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdata_q      <= 8'h00;
      wvalid_q     <= 1'b0;
      last_seen_q  <= 1'b0;
      tmo_q        <= '0;
      abort_cnt_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wvalid_q    <= 1'b0;
          last_seen_q <= 1'b0;
          tmo_q       <= '0;
          if (pick_any) begin
            grant_q  <= pick_grant;
            wdata_q  <= HDR_BASE | {7'd0, pick_grant};
            wvalid_q <= 1'b1;
          end
        end
        ST_HDR: begin
          tmo_q <= '0;
          if (in_xfer) begin
            wdata_q     <= g_data;
            wvalid_q    <= 1'b1;
            last_seen_q <= g_last;
          end else if (out_xfer) begin
            wvalid_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (in_xfer) begin
            wdata_q     <= g_data;
            wvalid_q    <= 1'b1;
            last_seen_q <= g_last;
            tmo_q       <= '0;
          end else if (out_xfer) begin
            wvalid_q <= 1'b0;
            if (last_seen_q) begin
              last_grant_q <= grant_q;
              last_seen_q  <= 1'b0;
            end
          end else if (tmo_hit) begin
            wdata_q  <= ABORT_BYTE;
            wvalid_q <= 1'b1;
            tmo_q    <= '0;
          end else if (tmo_tick) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_ABORT: begin
          if (out_xfer) begin
            wvalid_q     <= 1'b0;
            last_grant_q <= grant_q;
            abort_cnt_q  <= sat_inc8(abort_cnt_q);
          end
        end
        default: wvalid_q <= 1'b0;
      endcase
    end
  end

  assign o_wdata     = wdata_q;
  assign o_wvalid    = wvalid_q;
  assign o_grant     = grant_q;
  assign o_abort_cnt = abort_cnt_q;

endmodule
